// File: rtl/cla_chunk_sequencer_if.sv
// Operand/result handshake plus the narrow issue/return path to the shared CLA core.
// The slave modport is the sequencer's view; the master modport is the surrounding environment.
interface cla_chunk_sequencer_if #(
    parameter int N = 4,
    parameter int K = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N*K-1:0]   in_a;
    logic [N*K-1:0]   in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [N*K-1:0]   out_sum;
    logic             out_cout;
    logic             core_valid;
    logic [N-1:0]     core_a;
    logic [N-1:0]     core_b;
    logic             core_cin;
    logic             core_rvalid;
    logic [N-1:0]     core_sum;
    logic             core_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        input  core_rvalid, core_sum, core_cout,
        output in_ready, out_valid, out_sum, out_cout,
        output core_valid, core_a, core_b, core_cin
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        output core_rvalid, core_sum, core_cout,
        input  in_ready, out_valid, out_sum, out_cout,
        input  core_valid, core_a, core_b, core_cin
    );
endinterface

// File: rtl/cla_chunk_sequencer.sv
// Runs a W = N*K bit addition through one shared N-bit pipelined CLA core,
// one chunk at a time from the least-significant end, chaining carries between chunks.
module cla_chunk_sequencer #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    cla_chunk_sequencer_if.slave   bus
);
    localparam int W     = N * K;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;

    logic             in_ready_c;
    logic             out_valid_c;
    logic             core_valid_c;
    logic             accept;
    logic             chunk_done;

    assign accept     = bus.in_valid && in_ready_c;
    assign chunk_done = (state == WAIT) && bus.core_rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The carry register doubles as the running chunk carry and, in DONE, the final carry-out.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= bus.in_a;
                b_q     <= bus.in_b;
                carry_q <= bus.in_cin;
                idx     <= '0;
            end
            if (chunk_done) begin
                sum_q[idx*N +: N] <= bus.core_sum;
                carry_q           <= bus.core_cout;
                if (idx != LAST_IDX) begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        in_ready_c   = 1'b0;
        out_valid_c  = 1'b0;
        core_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                core_valid_c = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (bus.core_rvalid) begin
                    state_next = (idx == LAST_IDX) ? DONE : ISSUE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset is synchronous, so the first reset cycle still has the old state; mask outputs directly.
        if (reset) begin
            in_ready_c   = 1'b0;
            out_valid_c  = 1'b0;
            core_valid_c = 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_sum    = reset ? '0 : sum_q;
    assign bus.out_cout   = reset ? 1'b0 : carry_q;
    assign bus.core_valid = core_valid_c;
    assign bus.core_a     = core_valid_c ? a_q[idx*N +: N] : '0;
    assign bus.core_b     = core_valid_c ? b_q[idx*N +: N] : '0;
    assign bus.core_cin   = core_valid_c ? carry_q : 1'b0;

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Directed and random bench for cla_chunk_sequencer with a variable-latency core model
// and a queue of expected wide sums.
module tb_cla_chunk_sequencer;
    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cla_chunk_sequencer_if #(.N(N), .K(K)) bus ();

    cla_chunk_sequencer #(.N(N), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_out_cyc = 0;
    int core_lat_fixed = 2;
    bit spurious_en = 1'b0;

    logic [W:0] exp_q[$];
    logic       cin_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Core model: result appears rem cycles after the issue cycle; idle cycles may carry junk rvalid.
    int           rem = 0;
    bit           busy = 1'b0;
    logic [N:0]   pend;
    always @(posedge clk) begin
        if (reset) begin
            busy = 1'b0;
            rem  = 0;
            bus.core_rvalid <= 1'b0;
            bus.core_sum    <= '0;
            bus.core_cout   <= 1'b0;
        end else begin
            bus.core_rvalid <= 1'b0;
            if (bus.core_valid) begin
                check("core_overlap", 64'(busy), 64'd0);
                pend = {1'b0, bus.core_a} + {1'b0, bus.core_b} + (N+1)'(bus.core_cin);
                busy = 1'b1;
                rem  = (core_lat_fixed > 0) ? core_lat_fixed : int'($urandom_range(1, 6));
            end
            if (busy) begin
                rem--;
                if (rem == 0) begin
                    busy = 1'b0;
                    bus.core_rvalid <= 1'b1;
                    bus.core_sum    <= pend[N-1:0];
                    bus.core_cout   <= pend[N];
                end
            end else if (spurious_en && ($urandom_range(0, 3) == 0)) begin
                bus.core_rvalid <= 1'b1;
                bus.core_sum    <= N'($urandom);
                bus.core_cout   <= 1'($urandom);
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.core_valid) cin_log.push_back(bus.core_cin);
    end

    function automatic logic [3:0] packed_cins();
        logic [3:0] v = '0;
        for (int i = 0; i < cin_log.size() && i < 4; i++) v[i] = cin_log[i];
        return v;
    endfunction

    // Called at a negedge; returns at a negedge after the accept edge.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 64'd1, 64'd0);
        end else begin
            last_acc_cyc = cyc;
            exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_output(input string tag, input int hold);
        int n = 0;
        logic [W:0] exp;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            check({tag, "_out_timeout"}, 64'd1, 64'd0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_out"}, 64'd1, 64'd0);
            return;
        end
        exp = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_sum"}, 64'(bus.out_sum), 64'(exp[W-1:0]));
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
        end
        check({tag, "_sum"}, 64'(bus.out_sum), 64'(exp[W-1:0]));
        check({tag, "_cout"}, 64'(bus.out_cout), 64'(exp[W]));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_post_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_core_valid", 64'(bus.core_valid), 64'd0);
        check("rst_out_sum", 64'(bus.out_sum), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_core_valid", 64'(bus.core_valid), 64'd0);
        check("post_rst_out_sum", 64'(bus.out_sum), 64'd0);
        check("post_rst_out_cout", 64'(bus.out_cout), 64'd0);

        // Basic addition at fixed latency 2.
        cin_log.delete();
        apply_stimulus(16'h1234, 16'h4321, 1'b0);
        check_output("basic", 0);
        check("basic_latency", 64'(last_out_cyc - last_acc_cyc), 64'd13);
        check("basic_issues", 64'(cin_log.size()), 64'd4);
        check("basic_cins", 64'(packed_cins()), 64'h0);

        // Full carry ripple across every chunk.
        cin_log.delete();
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0);
        check_output("ripple", 0);
        check("ripple_issues", 64'(cin_log.size()), 64'd4);
        check("ripple_cins", 64'(packed_cins()), 64'he);
        cin_log.delete();
        apply_stimulus(16'hFFFF, 16'h0000, 1'b1);
        check_output("cin_ripple", 0);
        check("cin_ripple_cins", 64'(packed_cins()), 64'hf);

        // Backpressure in DONE with a request already waiting.
        apply_stimulus(16'h0F0F, 16'h0101, 1'b0);
        begin
            int n = 0;
            logic [W:0] exp;
            while (!bus.out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("bp_reach_done", 64'(bus.out_valid), 64'd1);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            bus.in_valid = 1'b1;
            bus.in_a     = 16'h1111;
            bus.in_b     = 16'h2222;
            bus.in_cin   = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("bp_valid", 64'(bus.out_valid), 64'd1);
                check("bp_sum", 64'(bus.out_sum), 64'(exp[W-1:0]));
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            end
            check("bp_cout", 64'(bus.out_cout), 64'(exp[W]));
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("bp_idle_valid", 64'(bus.out_valid), 64'd0);
            check("bp_idle_ready", 64'(bus.in_ready), 64'd1);
            exp_q.push_back({1'b0, 16'h1111} + {1'b0, 16'h2222} + 17'd1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("bp_accepted", 64'(bus.in_ready), 64'd0);
            check("bp_issue", 64'(bus.core_valid), 64'd1);
            check_output("bp_next", 0);
        end

        // Random operands, random core latency, junk rvalid outside WAIT.
        core_lat_fixed = 0;
        spurious_en    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            apply_stimulus(ra, rb, rc);
            check_output("rand", int'($urandom_range(0, 2)));
        end
        spurious_en = 1'b0;
        repeat (2) @(negedge clk);

        // Abort in WAIT of chunk 2, then a clean operation.
        core_lat_fixed = 4;
        cin_log.delete();
        apply_stimulus(16'h1234, 16'h1111, 1'b0);
        begin
            int n = 0;
            while (cin_log.size() < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("abort_reach_chunk2", 64'(cin_log.size()), 64'd3);
            check("abort_in_wait", 64'(bus.core_valid), 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(bus.in_ready), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_core_valid", 64'(bus.core_valid), 64'd0);
        check("abort_out_sum", 64'(bus.out_sum), 64'd0);
        check("abort_out_cout", 64'(bus.out_cout), 64'd0);
        check("abort_core_a", 64'(bus.core_a), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_idle_ready", 64'(bus.in_ready), 64'd1);
        check("abort_idle_sum", 64'(bus.out_sum), 64'd0);
        core_lat_fixed = 2;
        apply_stimulus(16'h8000, 16'h8000, 1'b0);
        check_output("after_abort", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cla_chunk_sequencer.md
Name: cla_chunk_sequencer

Overview:
- Sequences one shared, pipelined N-bit carry-lookahead adder core to perform W = N*K-bit additions.
- Splits each wide operation into K chunks, least-significant chunk first.
- Chains the carry-out of each chunk into the carry-in of the next.
- Sits between a valid/ready operand source and the pipelined CLA core; the core shares the same clk and reset.

Parameters:
N, 4, width of the CLA core in bits
K, 4, number of chunks per operation; operand width W = N*K

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  sequencer can accept a request
in_a  input  N*K  operand A
in_b  input  N*K  operand B
in_cin  input  1  carry-in of the wide addition
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  N*K  wide sum
out_cout  output  1  carry-out of the most-significant chunk
core_valid  output  1  issue strobe to CLA core
core_a  output  N  chunk of A issued to core
core_b  output  N  chunk of B issued to core
core_cin  output  1  carry-in issued to core
core_rvalid  input  1  core result valid
core_sum  input  N  core chunk sum
core_cout  input  1  core chunk carry-out

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset: state returns to IDLE and the chunk index is cleared to 0. All captured operands, the accumulated sum and the carry register clear to 0.
- Outputs during reset: in_ready=0 and out_valid=0; out_sum, out_cout, core_valid, core_a, core_b and core_cin are all 0.
- After reset: in_ready=1 in the first cycle after reset deasserts.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, capture in_a, in_b and in_cin; set carry register = in_cin and idx=0; go to ISSUE.
- ISSUE:
  - core_valid=1 for exactly this one cycle.
  - core_a = A[idx*N +: N], core_b = B[idx*N +: N], core_cin = carry register.
  - Go to WAIT.
- WAIT:
  - core_valid=0.
  - On core_rvalid: write core_sum into sum[idx*N +: N] and set carry register = core_cout.
  - If idx==K-1, go to DONE; otherwise idx=idx+1 and go to ISSUE.
  - The core latency is not assumed; WAIT holds indefinitely until core_rvalid.
- DONE:
  - out_valid=1; out_sum = sum register; out_cout = carry register.
  - out_sum and out_cout are held stable while out_ready=0.
  - On out_ready, go to IDLE. in_ready becomes 1 the following cycle; there is no same-cycle re-accept.
- in_ready is 0 in every state except IDLE. in_valid is ignored outside IDLE.
- At most one chunk is outstanding in the core at any time.
- core_rvalid outside WAIT is ignored; no state or data change results.
- Latency: for a core with fixed latency L (rvalid L cycles after the issue cycle), out_valid asserts K*(L+1)+1 cycles after the acceptance cycle. For L=2, K=4 this is 13 cycles.
- Arithmetic: out_sum and out_cout together equal in_a + in_b + in_cin as a (W+1)-bit result, so overflow appears only on out_cout.
- Reset mid-operation: the operation is aborted with no partial output. The core is reset in the same cycle, so no stale result reaches a later operation.
- out_sum drives the registered sum in all states. Its value outside DONE is not meaningful except after reset, when it is 0.

Test Plan:
1. Reset held 3 cycles, then released -> in_ready=1, and out_valid, core_valid, out_sum, out_cout all 0.
2. N=4, K=4, core L=2; a=0x1234, b=0x4321, cin=0 -> exactly 4 core_valid pulses with core_cin 0,0,0,0; out_sum=0x5555, out_cout=0; out_valid 13 cycles after the accept cycle.
3. a=0xFFFF, b=0x0001, cin=0 -> core_cin sequence 0,1,1,1; out_sum=0x0000, out_cout=1. Then a=0xFFFF, b=0x0000, cin=1 -> out_sum=0x0000, out_cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_valid and out_sum stable, in_ready=0, no accept. out_ready=1 -> IDLE, then the next operation is accepted one cycle later.
5. Variable-latency core model (rvalid 1-6 cycles after issue, random) plus spurious core_rvalid pulses in IDLE and DONE -> 200 random operations all match the (W+1)-bit reference sum.
6. Assert reset during WAIT of chunk 2 -> next cycle IDLE with all outputs 0. Then a=0x8000, b=0x8000, cin=0 completes with out_sum=0x0000, out_cout=1.
